input_debouncer: RTL and testbench
==================================

# input_debouncer

Two-channel synchronizer and debouncer for raw push-button/switch inputs. It sits directly upstream of the basic logic-gate blocks such as the OR gate and drives their `in1`/`in2` operands with clean, single-transition levels. Each channel double-flops its asynchronous input, then accepts a new level only after it has stayed stable for a programmable number of clock cycles. Optional one-cycle edge pulses are provided for counters and FSMs further downstream.

## Interface
Parameters:
- `CNT_W`, default 16: width of each channel's stability counter.
- `STABLE_CYCLES`, default 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz).
  - Legal range: 1 ≤ `STABLE_CYCLES` ≤ 2^`CNT_W` − 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in1_raw`  input  1  raw, asynchronous switch input, channel 1.
- `in2_raw`  input  1  raw, asynchronous switch input, channel 2.
- `in1`  output  1  debounced level, channel 1 (feeds the gate's `in1`).
- `in2`  output  1  debounced level, channel 2 (feeds the gate's `in2`).
- `in1_rise`, `in1_fall`  output  1 each  one-cycle edge pulses, channel 1. Present only with `DEBOUNCE_EDGE_DETECT_EN`.
- `in2_rise`, `in2_fall`  output  1 each  one-cycle edge pulses, channel 2. Present only with `DEBOUNCE_EDGE_DETECT_EN`.

## Operation
- Each channel is fully independent: no shared state between channels.
- Synchronizer: `s1 <= raw`, `s2 <= s1`. Only `s2` is used downstream.
- Stability counter `cnt` (`CNT_W` bits) and registered output `lvl`:
  - If `s2 == lvl`: `cnt <= 0`.
  - If `s2 != lvl` and `cnt == STABLE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`.
  - Otherwise (`s2 != lvl`): `cnt <= cnt + 1`.
- Glitch rejection: any return of `s2` to `lvl` before the count completes clears `cnt`. Bounces shorter than `STABLE_CYCLES` cycles never reach the output.
- `cnt` never exceeds `STABLE_CYCLES-1`, so it cannot wrap.
- Edge pulses (when compiled in) are registered: `rise <= s2 & ~lvl & (cnt == STABLE_CYCLES-1)`, and `fall` is the mirror. Each pulse is high in exactly the cycle `lvl` first shows the new value.
- Reset (at any time, including mid-count): `s1`, `s2`, `cnt` and `lvl` go to 0, and all pulses go to 0. Reset values: `in1 = in2 = 0` and all pulses 0.
- After reset release with `raw = 1`, the channel performs a normal 0→1 acceptance and emits a `rise` pulse.

## Timing
- Latency: the new raw level is first sampled at edge 0. With the level held, `lvl` changes at edge `STABLE_CYCLES+1`, giving `STABLE_CYCLES+2` edges total. Example: `STABLE_CYCLES = 1` updates at edge 2.
- Minimum spacing between two accepted transitions on one channel: `STABLE_CYCLES` cycles.
- Simultaneous transitions on both channels are processed independently, with identical latency.
- Outputs are glitch-free register outputs and are safe to drive combinational gates directly.

## Configuration
- Macro `DEBOUNCE_EDGE_DETECT_EN`:
  - Defined: the four `*_rise`/`*_fall` ports and their registers exist, with behaviour as above.
  - Undefined: the ports and registers are omitted. Level outputs are bit-identical in both builds.

## Structure
- Package `debounce_pkg`:
  - `DEBOUNCE_CNT_W_DEFAULT` = 16
  - `DEBOUNCE_STABLE_DEFAULT` = 50000
  - `DEBOUNCE_SIM_STABLE` = 4, the bench value
- Sub-module `debounce_channel`: synchronizer, counter, level register and optional edge registers for one input.
  - Instantiated twice by `input_debouncer`, parameterized by `CNT_W`/`STABLE_CYCLES`.

## Test plan
All scenarios use `STABLE_CYCLES = 4`, `CNT_W = 4`.
- Reset: assert `rst_n = 0` with `in1_raw = in2_raw = 1` → `in1 = in2 = 0` and all pulses 0 immediately, regardless of `clk`.
- Clean step: `in1_raw` 0→1 just before edge 0 and held → `in1` becomes 1 after edge 5. `in1_rise` is high for exactly that one cycle. `in2` is unchanged.
- Bounce rejection: on `in2_raw`, pulses of 1,0,1,0 lasting 3 cycles each, then settle at 1 → no output change during the bounce. `in2` rises 6 cycles after the final settle edge, with a single `in2_rise`.
- Release: with `in1 = 1`, drop `in1_raw` to 0 and hold → `in1` falls after `STABLE_CYCLES+2` edges, with one `in1_fall`.
- Mid-count reset: assert `rst_n` after 2 counted cycles, then release with raw still 1 → counting restarts from 0. `in1` rises 6 edges after the first post-reset edge.
- Simultaneous channels with the macro undefined: step both raws together → `in1` and `in2` rise on the same edge, and the build has no pulse ports.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults for the input debouncer
package debounce_pkg;

   localparam int DEBOUNCE_CNT_W_DEFAULT  = 16;
   localparam int DEBOUNCE_STABLE_DEFAULT = 50000;
   localparam int DEBOUNCE_SIM_STABLE     = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronizer + stability-count debounce channel
// Edge pulse registers exist only with DEBOUNCE_EDGE_DETECT_EN.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int CNT_W         = DEBOUNCE_CNT_W_DEFAULT,
   parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
`ifdef DEBOUNCE_EDGE_DETECT_EN
   output logic rise,
   output logic fall,
`endif
   output logic lvl
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
      $error("debounce_channel: STABLE_CYCLES out of range for CNT_W");
   end

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic             done;

   // done marks the cycle in which a differing s2 has been stable long enough
   assign done = (s2 != lvl) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         cnt <= '0;
         lvl <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (done) begin
            lvl <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef DEBOUNCE_EDGE_DETECT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= done & s2;
         fall <= done & ~s2;
      end
   end
`endif

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two independent debounce channels feeding gate operands
// Optional edge pulse ports with DEBOUNCE_EDGE_DETECT_EN.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int CNT_W         = DEBOUNCE_CNT_W_DEFAULT,
   parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in1_raw,
   input  logic in2_raw,
`ifdef DEBOUNCE_EDGE_DETECT_EN
   output logic in1_rise,
   output logic in1_fall,
   output logic in2_rise,
   output logic in2_fall,
`endif
   output logic in1,
   output logic in2
);

   debounce_channel #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_ch1 (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (in1_raw),
`ifdef DEBOUNCE_EDGE_DETECT_EN
      .rise  (in1_rise),
      .fall  (in1_fall),
`endif
      .lvl   (in1)
   );

   debounce_channel #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_ch2 (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (in2_raw),
`ifdef DEBOUNCE_EDGE_DETECT_EN
      .rise  (in2_rise),
      .fall  (in2_fall),
`endif
      .lvl   (in2)
   );

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench, STABLE_CYCLES=4, CNT_W=4
// Pulse checks are included when DEBOUNCE_EDGE_DETECT_EN is defined.
module tb_input_debouncer;
   import debounce_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic in1_raw;
   logic in2_raw;
   logic in1;
   logic in2;
`ifdef DEBOUNCE_EDGE_DETECT_EN
   logic in1_rise, in1_fall, in2_rise, in2_fall;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   input_debouncer #(
      .CNT_W         (4),
      .STABLE_CYCLES (DEBOUNCE_SIM_STABLE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in1_raw  (in1_raw),
      .in2_raw  (in2_raw),
`ifdef DEBOUNCE_EDGE_DETECT_EN
      .in1_rise (in1_rise),
      .in1_fall (in1_fall),
      .in2_rise (in2_rise),
      .in2_fall (in2_fall),
`endif
      .in1      (in1),
      .in2      (in2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      in1_raw = 1'b1;
      in2_raw = 1'b1;
      #2;
      total++;
      if ({in1, in2} !== 2'b00) begin
         bad++;
         $display("FAIL reset_levels got=%b want=00", {in1, in2});
      end
`ifdef DEBOUNCE_EDGE_DETECT_EN
      total++;
      if ({in1_rise, in1_fall, in2_rise, in2_fall} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_pulses got=%b want=0000", {in1_rise, in1_fall, in2_rise, in2_fall});
      end
`endif
      in1_raw = 1'b0;
      in2_raw = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      total++;
      if ({in1, in2} !== 2'b00) begin
         bad++;
         $display("FAIL post_reset_idle got=%b want=00", {in1, in2});
      end
   endtask

   task automatic test_clean_step();
      in1_raw = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if (in1 !== (k >= 5)) begin
            bad++;
            $display("FAIL clean_step_in1 edge=%0d got=%b want=%b", k, in1, (k >= 5));
         end
         total++;
         if (in2 !== 1'b0) begin
            bad++;
            $display("FAIL clean_step_in2 edge=%0d got=%b want=0", k, in2);
         end
`ifdef DEBOUNCE_EDGE_DETECT_EN
         total++;
         if (in1_rise !== (k == 5)) begin
            bad++;
            $display("FAIL clean_step_rise edge=%0d got=%b want=%b", k, in1_rise, (k == 5));
         end
`endif
      end
   endtask

   task automatic test_bounce();
      logic [3:0] pat;
      pat = 4'b1010;
      for (int p = 3; p >= 0; p--) begin
         in2_raw = pat[p];
         for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (in2 !== 1'b0) begin
               bad++;
               $display("FAIL bounce_hold phase=%0d got=%b want=0", 3 - p, in2);
            end
`ifdef DEBOUNCE_EDGE_DETECT_EN
            total++;
            if (in2_rise !== 1'b0) begin
               bad++;
               $display("FAIL bounce_rise phase=%0d got=%b want=0", 3 - p, in2_rise);
            end
`endif
         end
      end
      in2_raw = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if (in2 !== (k >= 5)) begin
            bad++;
            $display("FAIL bounce_settle edge=%0d got=%b want=%b", k, in2, (k >= 5));
         end
`ifdef DEBOUNCE_EDGE_DETECT_EN
         total++;
         if (in2_rise !== (k == 5)) begin
            bad++;
            $display("FAIL bounce_settle_rise edge=%0d got=%b want=%b", k, in2_rise, (k == 5));
         end
`endif
      end
   endtask

   task automatic test_release();
      in1_raw = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if (in1 !== (k < 5)) begin
            bad++;
            $display("FAIL release_in1 edge=%0d got=%b want=%b", k, in1, (k < 5));
         end
`ifdef DEBOUNCE_EDGE_DETECT_EN
         total++;
         if (in1_fall !== (k == 5)) begin
            bad++;
            $display("FAIL release_fall edge=%0d got=%b want=%b", k, in1_fall, (k == 5));
         end
`endif
      end
   endtask

   task automatic test_mid_count_reset();
      in1_raw = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({in1, in2} !== 2'b00) begin
         bad++;
         $display("FAIL midreset_levels got=%b want=00", {in1, in2});
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if (in1 !== (k >= 5)) begin
            bad++;
            $display("FAIL midreset_in1 edge=%0d got=%b want=%b", k, in1, (k >= 5));
         end
`ifdef DEBOUNCE_EDGE_DETECT_EN
         total++;
         if (in1_rise !== (k == 5)) begin
            bad++;
            $display("FAIL midreset_rise edge=%0d got=%b want=%b", k, in1_rise, (k == 5));
         end
`endif
      end
   endtask

   task automatic test_simultaneous();
      // in2 was cleared by the mid-count reset and re-accepts first
      repeat (8) tick();
      total++;
      if ({in1, in2} !== 2'b11) begin
         bad++;
         $display("FAIL simul_pre got=%b want=11", {in1, in2});
      end
      in1_raw = 1'b0;
      in2_raw = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if ({in1, in2} !== {2{k < 5}}) begin
            bad++;
            $display("FAIL simul_fall edge=%0d got=%b want=%b", k, {in1, in2}, {2{k < 5}});
         end
      end
      in1_raw = 1'b1;
      in2_raw = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if ({in1, in2} !== {2{k >= 5}}) begin
            bad++;
            $display("FAIL simul_rise edge=%0d got=%b want=%b", k, {in1, in2}, {2{k >= 5}});
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_bounce();
      test_release();
      test_mid_count_reset();
      test_simultaneous();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
